control_sequencer: RTL and testbench

- Hardwired control unit that drives the datapath's control inputs, replacing the hand-sequenced stimulus currently used for bring-up.
- Runs fetch (T0–T2) and then a per-opcode execute sequence (T3–T7) from the contents of IR.
- Register selection is emitted as Gra/Grb/Grc plus Rin/Rout/BAout; a downstream select-and-encode block produces R0in..R15in and R0out..R15out.

---
 rtl/control_sequencer_pkg.sv | 46 ++++
 rtl/control_sequencer_if.sv | 37 +++
 rtl/control_sequencer_opcode_class_decode.sv | 40 ++++
 rtl/control_sequencer.sv | 139 +++++++++++++
 tb/tb_control_sequencer.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control sequencer.
// Opcodes, ALU codes, state encoding and IR field positions.
package cpu_defs;

  localparam int OPW  = 5;
  localparam int ALUW = 4;

  localparam int OP_HI = 31;
  localparam int OP_LO = 27;

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  localparam logic [ALUW-1:0] ALU_ADD = 4'd0;
  localparam logic [ALUW-1:0] ALU_SUB = 4'd1;
  localparam logic [ALUW-1:0] ALU_AND = 4'd2;
  localparam logic [ALUW-1:0] ALU_OR  = 4'd3;

  typedef enum logic [3:0] {
    RESET_S = 4'd0,
    T0      = 4'd1,
    T1      = 4'd2,
    T2      = 4'd3,
    T3      = 4'd4,
    T4      = 4'd5,
    T5      = 4'd6,
    T6      = 4'd7,
    T7      = 4'd8,
    HALT    = 4'd9
  } state_t;

  function automatic logic [OPW-1:0] op_field(input logic [31:0] ir);
    return ir[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Instruction/memory status in, datapath control strobes out.
interface control_sequencer_if;
  import cpu_defs::*;

  logic [31:0]     IR;
  logic            Mem_Ready;
  logic            Stop;

  logic            PCout, Zlowout, Zhighout, MDRout;
  logic            Cout, BAout, Rout;
  logic            PCin, IRin, MARin, MDRin, Yin;
  logic            Zin, Rin, HIin, LOin;
  logic            Gra, Grb, Grc;
  logic            IncPC, Read, Write;
  logic [ALUW-1:0] ALU_op;
  logic            Run;

  modport master (
    input  IR, Mem_Ready, Stop,
    output PCout, Zlowout, Zhighout, MDRout,
    output Cout, BAout, Rout,
    output PCin, IRin, MARin, MDRin, Yin,
    output Zin, Rin, HIin, LOin,
    output Gra, Grb, Grc,
    output IncPC, Read, Write, ALU_op, Run
  );

  modport slave (
    output IR, Mem_Ready, Stop,
    input  PCout, Zlowout, Zhighout, MDRout,
    input  Cout, BAout, Rout,
    input  PCin, IRin, MARin, MDRin, Yin,
    input  Zin, Rin, HIin, LOin,
    input  Gra, Grb, Grc,
    input  IncPC, Read, Write, ALU_op, Run
  );
endinterface

// File: rtl/control_sequencer_opcode_class_decode.sv
// Classifies the opcode field into an execute-sequence family
// and selects the ALU function for arithmetic/logic ops.
module opcode_class_decode
  import cpu_defs::*;
(
  input  logic [OPW-1:0]  op,
  output logic            is_rtype,
  output logic            is_imm,
  output logic            is_ld,
  output logic            is_ldi,
  output logic            is_st,
  output logic            is_halt,
  output logic [ALUW-1:0] alu_op
);

  always_comb begin
    is_rtype = 1'b0;
    is_imm   = 1'b0;
    is_ld    = 1'b0;
    is_ldi   = 1'b0;
    is_st    = 1'b0;
    is_halt  = 1'b0;
    alu_op   = ALU_ADD;
    case (op)
      OP_ADD:  is_rtype = 1'b1;
      OP_SUB:  begin is_rtype = 1'b1; alu_op = ALU_SUB; end
      OP_AND:  begin is_rtype = 1'b1; alu_op = ALU_AND; end
      OP_OR:   begin is_rtype = 1'b1; alu_op = ALU_OR;  end
      OP_ADDI: is_imm = 1'b1;
      OP_ANDI: begin is_imm = 1'b1; alu_op = ALU_AND; end
      OP_ORI:  begin is_imm = 1'b1; alu_op = ALU_OR;  end
      OP_LD:   is_ld   = 1'b1;
      OP_LDI:  is_ldi  = 1'b1;
      OP_ST:   is_st   = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer; outputs decode from the
// state register plus the opcode held stable in IR.
module control_sequencer
  import cpu_defs::*;
(
  input  logic                Clock,
  input  logic                Reset,
  control_sequencer_if.master bus
);

  state_t          state;
  logic            is_rtype, is_imm, is_ld;
  logic            is_ldi, is_st, is_halt;
  logic [ALUW-1:0] alu_op;
  logic            is_mem, is_addr, is_exec;
  logic            unused_ir;

  assign unused_ir = ^bus.IR[OP_LO-1:0];

  opcode_class_decode u_dec (
    .op       (op_field(bus.IR)),
    .is_rtype (is_rtype),
    .is_imm   (is_imm),
    .is_ld    (is_ld),
    .is_ldi   (is_ldi),
    .is_st    (is_st),
    .is_halt  (is_halt),
    .alu_op   (alu_op)
  );

  // ld/st share the base+offset address phase with ldi
  assign is_mem  = is_ld | is_st;
  assign is_addr = is_mem | is_ldi;
  assign is_exec = is_rtype | is_imm | is_addr;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= RESET_S;
    end else begin
      case (state)
        RESET_S: state <= T0;
        T0:      state <= bus.Stop ? HALT : T1;
        T1:      if (bus.Mem_Ready) state <= T2;
        T2:      state <= T3;
        T3: begin
          if (is_halt)      state <= HALT;
          else if (is_exec) state <= T4;
          else              state <= T0;
        end
        T4:      state <= T5;
        T5:      state <= is_mem ? T6 : T0;
        T6:      if (is_st || bus.Mem_Ready) state <= T7;
        T7:      if (is_ld || bus.Mem_Ready) state <= T0;
        HALT:    state <= HALT;
        default: state <= RESET_S;
      endcase
    end
  end

  always_comb begin
    bus.PCout    = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.Zhighout = 1'b0;
    bus.MDRout   = 1'b0;
    bus.Cout     = 1'b0;
    bus.BAout    = 1'b0;
    bus.Rout     = 1'b0;
    bus.PCin     = 1'b0;
    bus.IRin     = 1'b0;
    bus.MARin    = 1'b0;
    bus.MDRin    = 1'b0;
    bus.Yin      = 1'b0;
    bus.Zin      = 1'b0;
    bus.Rin      = 1'b0;
    bus.HIin     = 1'b0;
    bus.LOin     = 1'b0;
    bus.Gra      = 1'b0;
    bus.Grb      = 1'b0;
    bus.Grc      = 1'b0;
    bus.IncPC    = 1'b0;
    bus.Read     = 1'b0;
    bus.Write    = 1'b0;
    bus.ALU_op   = ALU_ADD;
    bus.Run      = (state != RESET_S) && (state != HALT);
    case (state)
      T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
      end
      T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
      end
      T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      T3: begin
        if (is_exec) begin
          bus.Grb   = 1'b1;
          bus.Yin   = 1'b1;
          bus.Rout  = ~is_addr;
          bus.BAout = is_addr;
        end
      end
      T4: begin
        bus.Zin    = is_exec;
        bus.Grc    = is_rtype;
        bus.Rout   = is_rtype;
        bus.Cout   = is_imm | is_addr;
        bus.ALU_op = is_addr ? ALU_ADD : alu_op;
      end
      T5: begin
        bus.Zlowout = is_exec;
        bus.MARin   = is_mem;
        bus.Gra     = is_exec & ~is_mem;
        bus.Rin     = is_exec & ~is_mem;
      end
      T6: begin
        bus.MDRin = is_mem;
        bus.Read  = is_ld;
        bus.Gra   = is_st;
        bus.Rout  = is_st;
      end
      T7: begin
        bus.MDRout = is_ld;
        bus.Gra    = is_ld;
        bus.Rin    = is_ld;
        bus.Write  = is_st;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed vector bench for control_sequencer.
// Each record: inputs for one cycle and the outputs expected in it.
module tb_control_sequencer;
  import cpu_defs::*;

  logic clk = 1'b0;
  logic rst;

  control_sequencer_if bus();

  control_sequencer dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  localparam logic [22:0] PCOUT   = 23'd1 << 0;
  localparam logic [22:0] ZLOWOUT = 23'd1 << 1;
  localparam logic [22:0] MDROUT  = 23'd1 << 3;
  localparam logic [22:0] COUT    = 23'd1 << 4;
  localparam logic [22:0] BAOUT   = 23'd1 << 5;
  localparam logic [22:0] ROUT    = 23'd1 << 6;
  localparam logic [22:0] PCIN    = 23'd1 << 7;
  localparam logic [22:0] IRIN    = 23'd1 << 8;
  localparam logic [22:0] MARIN   = 23'd1 << 9;
  localparam logic [22:0] MDRIN   = 23'd1 << 10;
  localparam logic [22:0] YIN     = 23'd1 << 11;
  localparam logic [22:0] ZIN     = 23'd1 << 12;
  localparam logic [22:0] RIN     = 23'd1 << 13;
  localparam logic [22:0] GRA     = 23'd1 << 16;
  localparam logic [22:0] GRB     = 23'd1 << 17;
  localparam logic [22:0] GRC     = 23'd1 << 18;
  localparam logic [22:0] INCPC   = 23'd1 << 19;
  localparam logic [22:0] READ    = 23'd1 << 20;
  localparam logic [22:0] WRITE   = 23'd1 << 21;
  localparam logic [22:0] RUN     = 23'd1 << 22;

  localparam logic [22:0] F0  = PCOUT | MARIN | INCPC | ZIN | RUN;
  localparam logic [22:0] F1  = ZLOWOUT | PCIN | READ | MDRIN | RUN;
  localparam logic [22:0] F2  = MDROUT | IRIN | RUN;
  localparam logic [22:0] RT3 = GRB | ROUT | YIN | RUN;
  localparam logic [22:0] RT4 = GRC | ROUT | ZIN | RUN;
  localparam logic [22:0] IT4 = COUT | ZIN | RUN;
  localparam logic [22:0] WB  = ZLOWOUT | GRA | RIN | RUN;
  localparam logic [22:0] AT3 = GRB | BAOUT | YIN | RUN;
  localparam logic [22:0] AT5 = ZLOWOUT | MARIN | RUN;
  localparam logic [22:0] LT6 = READ | MDRIN | RUN;
  localparam logic [22:0] LT7 = MDROUT | GRA | RIN | RUN;
  localparam logic [22:0] ST6 = GRA | ROUT | MDRIN | RUN;
  localparam logic [22:0] ST7 = WRITE | RUN;

  localparam logic [31:0] I_SUB  = 32'h20918000;
  localparam logic [31:0] I_LD   = 32'h00900045;
  localparam logic [31:0] I_ST   = 32'h1188001F;
  localparam logic [31:0] I_ADDI = 32'h610FFFFB;
  localparam logic [31:0] I_OR   = 32'h30000000;
  localparam logic [31:0] I_ANDI = 32'h68000000;
  localparam logic [31:0] I_LDI  = 32'h08000000;
  localparam logic [31:0] I_NOP  = 32'hD0000000;
  localparam logic [31:0] I_UND  = 32'hF8000000;
  localparam logic [31:0] I_HALT = 32'hD8000000;

  typedef struct {
    logic [31:0] ir;
    logic        mr;
    logic        stop;
    logic        rst;
    logic [22:0] ctl;
    logic [3:0]  alu;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [22:0] ctl_now();
    return {bus.Run, bus.Write, bus.Read, bus.IncPC,
            bus.Grc, bus.Grb, bus.Gra, bus.LOin, bus.HIin,
            bus.Rin, bus.Zin, bus.Yin, bus.MDRin, bus.MARin,
            bus.IRin, bus.PCin, bus.Rout, bus.BAout, bus.Cout,
            bus.MDRout, bus.Zhighout, bus.Zlowout, bus.PCout};
  endfunction

  function automatic void v(logic [31:0] ir, logic mr,
                            logic stop, logic r,
                            logic [22:0] ctl, logic [3:0] alu);
    vec_t e;
    e.ir = ir; e.mr = mr; e.stop = stop; e.rst = r;
    e.ctl = ctl; e.alu = alu;
    vecs.push_back(e);
  endfunction

  function automatic void fetch(logic [31:0] ir);
    v(ir, 1'b1, 1'b0, 1'b0, F0, 4'd0);
    v(ir, 1'b1, 1'b0, 1'b0, F1, 4'd0);
    v(ir, 1'b1, 1'b0, 1'b0, F2, 4'd0);
  endfunction

  function automatic void ex(logic [31:0] ir, logic mr,
                             logic [22:0] ctl, logic [3:0] alu);
    v(ir, mr, 1'b0, 1'b0, ctl, alu);
  endfunction

  task automatic check(string name, logic [22:0] ectl,
                       logic [3:0] ealu);
    logic [22:0] c;
    c = ctl_now();
    total++;
    if (c !== ectl || bus.ALU_op !== ealu) begin
      bad++;
      $display("FAIL %s: ctl=%06h alu=%0d want ctl=%06h alu=%0d",
               name, c, bus.ALU_op, ectl, ealu);
    end
    total++;
    if ($countones(c[6:0]) > 1) begin
      bad++;
      $display("FAIL %s busdrv: drivers=%07b want <=1 set",
               name, c[6:0]);
    end
  endtask

  task automatic cyc(string name, logic r, logic mr, logic stop,
                     logic [31:0] ir, logic [22:0] ectl,
                     logic [3:0] ealu);
    @(negedge clk);
    rst = r;
    bus.Mem_Ready = mr;
    bus.Stop = stop;
    bus.IR = ir;
    #1;
    check(name, ectl, ealu);
  endtask

  initial begin
    rst = 1'b1;
    bus.IR = I_SUB;
    bus.Mem_Ready = 1'b0;
    bus.Stop = 1'b0;
    @(posedge clk);

    v(I_SUB, 1'b1, 1'b0, 1'b1, 23'd0, 4'd0);
    v(I_SUB, 1'b1, 1'b0, 1'b0, 23'd0, 4'd0);
    fetch(I_SUB);
    ex(I_SUB, 1'b1, RT3, 4'd0);
    ex(I_SUB, 1'b1, RT4, 4'd1);
    ex(I_SUB, 1'b1, WB, 4'd0);
    fetch(I_LD);
    ex(I_LD, 1'b1, AT3, 4'd0);
    ex(I_LD, 1'b1, IT4, 4'd0);
    ex(I_LD, 1'b1, AT5, 4'd0);
    ex(I_LD, 1'b0, LT6, 4'd0);
    ex(I_LD, 1'b0, LT6, 4'd0);
    ex(I_LD, 1'b0, LT6, 4'd0);
    ex(I_LD, 1'b1, LT6, 4'd0);
    ex(I_LD, 1'b1, LT7, 4'd0);
    fetch(I_ST);
    ex(I_ST, 1'b1, AT3, 4'd0);
    ex(I_ST, 1'b1, IT4, 4'd0);
    ex(I_ST, 1'b1, AT5, 4'd0);
    ex(I_ST, 1'b1, ST6, 4'd0);
    ex(I_ST, 1'b1, ST7, 4'd0);
    fetch(I_ADDI);
    ex(I_ADDI, 1'b1, RT3, 4'd0);
    ex(I_ADDI, 1'b1, IT4, 4'd0);
    ex(I_ADDI, 1'b1, WB, 4'd0);
    fetch(I_OR);
    ex(I_OR, 1'b1, RT3, 4'd0);
    ex(I_OR, 1'b1, RT4, 4'd3);
    ex(I_OR, 1'b1, WB, 4'd0);
    fetch(I_ANDI);
    ex(I_ANDI, 1'b1, RT3, 4'd0);
    ex(I_ANDI, 1'b1, IT4, 4'd2);
    ex(I_ANDI, 1'b1, WB, 4'd0);
    fetch(I_LDI);
    ex(I_LDI, 1'b1, AT3, 4'd0);
    ex(I_LDI, 1'b1, IT4, 4'd0);
    ex(I_LDI, 1'b1, WB, 4'd0);
    fetch(I_NOP);
    ex(I_NOP, 1'b1, RUN, 4'd0);
    fetch(I_UND);
    ex(I_UND, 1'b1, RUN, 4'd0);
    fetch(I_HALT);
    ex(I_HALT, 1'b1, RUN, 4'd0);
    ex(I_HALT, 1'b1, 23'd0, 4'd0);

    for (int i = 0; i < vecs.size(); i++)
      cyc($sformatf("vec%0d", i), vecs[i].rst, vecs[i].mr,
          vecs[i].stop, vecs[i].ir, vecs[i].ctl, vecs[i].alu);

    // HALT must persist with Stop low and memory idle
    for (int i = 0; i < 20; i++)
      cyc($sformatf("halt%0d", i), 1'b0, 1'b0, 1'b0,
          I_NOP, 23'd0, 4'd0);
    cyc("halt_rst", 1'b1, 1'b1, 1'b0, I_NOP, 23'd0, 4'd0);
    cyc("halt_rs_t0", 1'b0, 1'b1, 1'b0, I_NOP, 23'd0, 4'd0);
    cyc("halt_t0", 1'b0, 1'b1, 1'b1, I_NOP, F0, 4'd0);
    for (int i = 0; i < 4; i++)
      cyc($sformatf("stop_halt%0d", i), 1'b0, 1'b1, 1'b0,
          I_NOP, 23'd0, 4'd0);

    cyc("rst1", 1'b1, 1'b0, 1'b0, I_NOP, 23'd0, 4'd0);
    cyc("rst1_rel", 1'b0, 1'b0, 1'b0, I_NOP, 23'd0, 4'd0);
    cyc("t0_b", 1'b0, 1'b0, 1'b0, I_NOP, F0, 4'd0);
    cyc("t1_wait0", 1'b0, 1'b0, 1'b0, I_NOP, F1, 4'd0);
    cyc("t1_wait1", 1'b0, 1'b0, 1'b0, I_NOP, F1, 4'd0);
    cyc("t1_rst", 1'b1, 1'b1, 1'b0, I_NOP, F1, 4'd0);
    cyc("t1_rs", 1'b0, 1'b1, 1'b0, I_NOP, 23'd0, 4'd0);
    cyc("t0_c", 1'b1, 1'b1, 1'b1, I_NOP, F0, 4'd0);
    cyc("rst_stop", 1'b0, 1'b1, 1'b0, I_NOP, 23'd0, 4'd0);
    cyc("t0_d", 1'b0, 1'b1, 1'b0, I_NOP, F0, 4'd0);
    cyc("t1_d", 1'b0, 1'b1, 1'b0, I_NOP, F1, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
